// File: rtl/common_cross_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : common_cross_pkg
//  Description : Shared helpers for the cross-buffer family: ceiling log2
//                and a legal-range guard for requester counts.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef COMMON_CROSS_PKG_MACROS
`define COMMON_CROSS_PKG_MACROS
// Elaboration-time guard; expands to a labelled generate-if in module scope.
`define COMMON_CROSS_CHECK_PORT_COUNT(N) \
  if (((N) < 2) || ((N) > 8)) begin : g_bad_port_count \
    $error("PORT_COUNT must be in the range 2..8"); \
  end
`endif

package common_cross_pkg;

  // Ceiling log2, never below 1 so a 2-port index still has one bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/common_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : common_rr_pick
//  Description : Combinational round-robin selector. Searches the valid
//                vector upward from ptr (wrapping modulo PORT_COUNT) and
//                returns the first valid index plus an any-valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module common_rr_pick
  import common_cross_pkg::*;
#(
  parameter int PORT_COUNT = 4,
  localparam int SRC_WIDTH = clog2(PORT_COUNT)
) (
  input  logic [PORT_COUNT-1:0] valid,
  input  logic [SRC_WIDTH-1:0]  ptr,
  output logic [SRC_WIDTH-1:0]  winner,
  output logic                  any
);

  // One spare bit so ptr + offset cannot overflow before the wrap.
  logic [SRC_WIDTH:0] idx;

  // Walk offsets from far to near so the closest valid port to ptr wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = PORT_COUNT - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (SRC_WIDTH+1)'(i);
      if (idx >= (SRC_WIDTH+1)'(PORT_COUNT)) begin
        idx = idx - (SRC_WIDTH+1)'(PORT_COUNT);
      end
      if (valid[idx[SRC_WIDTH-1:0]]) begin
        winner = idx[SRC_WIDTH-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/common_cross_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : common_cross_arbiter_rr
//  Description : PORT_COUNT-way round-robin stream arbiter feeding a
//                registered 2-entry in-order buffer. Upstream acceptance
//                depends only on buffer occupancy, so downstream ready never
//                reaches prev_o_ready combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module common_cross_arbiter_rr
  import common_cross_pkg::*;
#(
  parameter int BUFFER_WIDTH = 32,
  parameter int PORT_COUNT   = 4,
  localparam int SRC_WIDTH   = clog2(PORT_COUNT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PORT_COUNT*BUFFER_WIDTH-1:0] prev_i_data,
  input  logic [PORT_COUNT-1:0]            prev_i_valid,
  output logic [PORT_COUNT-1:0]            prev_o_ready,
  output logic [BUFFER_WIDTH-1:0]          next_o_data,
  output logic [SRC_WIDTH-1:0]             next_o_src,
  output logic                             next_o_valid,
  input  logic                             next_i_ready
);

  `COMMON_CROSS_CHECK_PORT_COUNT(PORT_COUNT)

  logic [1:0]              count;
  logic [SRC_WIDTH-1:0]    rr_ptr;
  logic [BUFFER_WIDTH-1:0] head_data;
  logic [SRC_WIDTH-1:0]    head_src;
  logic [BUFFER_WIDTH-1:0] tail_data;
  logic [SRC_WIDTH-1:0]    tail_src;

  logic [SRC_WIDTH-1:0]    winner;
  logic                    any_valid;
  logic                    space;
  logic                    push;
  logic                    pop;
  logic [BUFFER_WIDTH-1:0] port_data [PORT_COUNT];
  logic [BUFFER_WIDTH-1:0] win_data;
  logic [SRC_WIDTH-1:0]    ptr_after_win;

  common_rr_pick #(
    .PORT_COUNT (PORT_COUNT)
  ) u_pick (
    .valid  (prev_i_valid),
    .ptr    (rr_ptr),
    .winner (winner),
    .any    (any_valid)
  );

  for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
    assign port_data[p]    = prev_i_data[p*BUFFER_WIDTH +: BUFFER_WIDTH];
    assign prev_o_ready[p] = push && (winner == SRC_WIDTH'(p));
  end

  // Space comes from registered occupancy only; reset suppresses any handshake.
  assign space    = (count != 2'd2);
  assign push     = space && any_valid && !reset;
  assign pop      = next_o_valid && next_i_ready && !reset;
  assign win_data = port_data[winner];

  // Explicit wrap keeps non-power-of-2 port counts inside 0..PORT_COUNT-1.
  assign ptr_after_win = (winner == SRC_WIDTH'(PORT_COUNT - 1)) ? '0 : winner + SRC_WIDTH'(1);

  assign next_o_valid = (count != 2'd0);
  assign next_o_data  = head_data;
  assign next_o_src   = head_src;

  // Buffer occupancy, entry shifting and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      rr_ptr    <= '0;
      head_data <= '0;
      head_src  <= '0;
      tail_data <= '0;
      tail_src  <= '0;
    end else begin
      if (push) begin
        rr_ptr <= ptr_after_win;
      end
      if (push && pop) begin
        // Only reachable at count 1: the departing head is replaced in place.
        head_data <= win_data;
        head_src  <= winner;
      end else if (push) begin
        if (count == 2'd0) begin
          head_data <= win_data;
          head_src  <= winner;
        end else begin
          tail_data <= win_data;
          tail_src  <= winner;
        end
        count <= count + 2'd1;
      end else if (pop) begin
        if (count == 2'd2) begin
          head_data <= tail_data;
          head_src  <= tail_src;
        end
        count <= count - 2'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_common_cross_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_common_cross_arbiter_rr
//  Description : Scoreboard bench for the round-robin cross arbiter. The
//                bench predicts each grant from its own pointer, queues the
//                granted {src,data} and compares it when the head drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_common_cross_arbiter_rr;

  localparam int BW = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk;
  logic            reset;
  logic [N*BW-1:0] prev_i_data;
  logic [N-1:0]    prev_i_valid;
  logic [N-1:0]    prev_o_ready;
  logic [BW-1:0]   next_o_data;
  logic [SW-1:0]   next_o_src;
  logic            next_o_valid;
  logic            next_i_ready;

  common_cross_arbiter_rr #(
    .BUFFER_WIDTH (BW),
    .PORT_COUNT   (N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .prev_i_data  (prev_i_data),
    .prev_i_valid (prev_i_valid),
    .prev_o_ready (prev_o_ready),
    .next_o_data  (next_o_data),
    .next_o_src   (next_o_src),
    .next_o_valid (next_o_valid),
    .next_i_ready (next_i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [BW-1:0] data;
  } entry_t;

  entry_t        sb[$];
  int            m_ptr;
  logic [BW-1:0] pd [N];
  int            checks;
  int            errors;
  int            grants_seen [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic rst_in, input logic [N-1:0] v, input logic rdy);
    int            w;
    logic          found;
    logic [N-1:0]  exp_ready;
    entry_t        e;
    reset        = rst_in;
    prev_i_valid = v;
    next_i_ready = rdy;
    for (int i = 0; i < N; i++) prev_i_data[i*BW +: BW] = pd[i];
    #1;
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && v[(m_ptr + k) % N]) begin
        found = 1'b1;
        w     = (m_ptr + k) % N;
      end
    end
    exp_ready = '0;
    if (!rst_in && found && sb.size() < 2) exp_ready[w] = 1'b1;
    check("prev_o_ready", 64'(prev_o_ready), 64'(exp_ready));
    check("next_o_valid", 64'(next_o_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("next_o_data", 64'(next_o_data), 64'(sb[0].data));
      check("next_o_src",  64'(next_o_src),  64'(sb[0].src));
    end
    if (rst_in) begin
      sb.delete();
      m_ptr = 0;
    end else begin
      if (sb.size() != 0 && rdy) void'(sb.pop_front());
      if (exp_ready != '0) begin
        e.src  = SW'(w);
        e.data = pd[w];
        sb.push_back(e);
        m_ptr = (w + 1) % N;
        grants_seen[w]++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_ptr  = 0;
    reset  = 1'b1;
    prev_i_valid = '0;
    prev_i_data  = '0;
    next_i_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pd[i] = BW'(32'hA0 + i);
      grants_seen[i] = 0;
    end
    @(negedge clk);

    // Reset held with every requester valid: nothing may be accepted.
    for (int c = 0; c < 3; c++) step(1'b1, 4'b1111, 1'b1);

    // Saturation: first grant to port 0, then 0,1,2,3 repeating.
    for (int c = 0; c < 12; c++) step(1'b0, 4'b1111, 1'b1);
    check("saturation_fair", 64'(grants_seen[0] + grants_seen[3]), 64'd6);

    // Sparse: only ports 1 and 3, pointer wraps past the top.
    for (int c = 0; c < 8; c++) step(1'b0, 4'b1010, 1'b1);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0000, 1'b1);

    // Backpressure: fill both entries, then drain in order.
    step(1'b1, 4'b0000, 1'b0);
    pd[0] = 32'h11;
    pd[1] = 32'h22;
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    pd[1] = 32'hDEAD_0001;
    for (int c = 0; c < 3; c++) step(1'b0, 4'b1111, 1'b0);
    check("bp_head_data", 64'(next_o_data), 64'h11);
    check("bp_full_ready", 64'(prev_o_ready), 64'd0);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0000, 1'b1);

    // Single steady requester: push and pop every cycle at count 1.
    for (int c = 0; c < 8; c++) begin
      pd[2] = BW'(32'h200 + c);
      step(1'b0, 4'b0100, 1'b1);
    end
    check("steady_valid", 64'(next_o_valid), 64'd1);
    check("steady_data", 64'(next_o_data), 64'h207);

    // Mid-stream reset with a full buffer; nothing stale may emerge.
    pd[0] = 32'h55;
    pd[3] = 32'h66;
    step(1'b0, 4'b1000, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    check("post_reset_valid", 64'(next_o_valid), 64'd0);
    pd[1] = 32'h77;
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b0, 4'b0000, 1'b1);

    // Random traffic with random backpressure and churning payloads.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) pd[i] = $urandom;
      step(($urandom_range(0, 59) == 0), N'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
